// File: rtl/gwas_stream_pkg.sv
// rtl/gwas_stream_pkg.sv - shared widths, words-per-beat and streamer state encoding
package gwas_stream_pkg;
  localparam int GS_DATA_WIDTH  = 512;
  localparam int GS_EMPTY_WIDTH = 6;
  localparam int GS_PAIR_WIDTH  = 32;
  localparam int GS_CNT_WIDTH   = 16;
  localparam int GS_WPB         = GS_DATA_WIDTH / GS_PAIR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_SEND,
    ST_DONE
  } state_e;
endpackage

// File: rtl/snp_pair_streamer_if.sv
// rtl/snp_pair_streamer_if.sv - control, show-ahead pop and Avalon-ST source signals
interface snp_pair_streamer_if #(
  parameter int DATA_WIDTH  = 512,
  parameter int EMPTY_WIDTH = 6,
  parameter int PAIR_WIDTH  = 32,
  parameter int CNT_WIDTH   = 16
);
  logic                   start;
  logic [CNT_WIDTH-1:0]   pair_num;
  logic [PAIR_WIDTH-1:0]  pair_data;
  logic                   pair_rd_en;
  logic [DATA_WIDTH-1:0]  src_data;
  logic                   src_valid;
  logic                   src_ready;
  logic [EMPTY_WIDTH-1:0] src_empty;
  logic                   src_sop;
  logic                   src_eop;
  logic                   busy;
  logic                   done;

  modport master (
    input  start, pair_num, pair_data, src_ready,
    output pair_rd_en, src_data, src_valid, src_empty, src_sop, src_eop, busy, done
  );
  modport slave (
    output start, pair_num, pair_data, src_ready,
    input  pair_rd_en, src_data, src_valid, src_empty, src_sop, src_eop, busy, done
  );
endinterface

// File: rtl/avst_byte_reverse.sv
// rtl/avst_byte_reverse.sv - combinational byte swap between internal and network order
module avst_byte_reverse #(
  parameter int DATA_WIDTH = 512
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o
);
  localparam int NB = DATA_WIDTH / 8;

  for (genvar i = 0; i < NB; i++) begin : g_byte
    assign data_o[8*i +: 8] = data_i[8*(NB-1-i) +: 8];
  end
endmodule

// File: rtl/snp_pair_streamer.sv
// rtl/snp_pair_streamer.sv - drains the SNP-pair FIFO into one count-prefixed Avalon-ST packet
module snp_pair_streamer
  import gwas_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = GS_DATA_WIDTH,
  parameter int EMPTY_WIDTH = GS_EMPTY_WIDTH,
  parameter int PAIR_WIDTH  = GS_PAIR_WIDTH,
  parameter int CNT_WIDTH   = GS_CNT_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  snp_pair_streamer_if.master bus
);
  localparam int WPB            = DATA_WIDTH / PAIR_WIDTH;
  localparam int SLOT_W         = $clog2(WPB) + 1;
  localparam int BYTES_PER_PAIR = PAIR_WIDTH / 8;

  state_e                 state_q;
  logic [CNT_WIDTH-1:0]   total_q;
  logic [CNT_WIDTH-1:0]   left_q;
  logic [SLOT_W-1:0]      slot_q;
  logic [DATA_WIDTH-1:0]  pack_q;
  logic                   valid_q, sop_q, eop_q, busy_q, done_q;
  logic [EMPTY_WIDTH-1:0] empty_q;

  logic                   pop;
  logic [CNT_WIDTH-1:0]   left_d;
  logic [SLOT_W-1:0]      slot_d;
  logic                   fill_end;
  logic [EMPTY_WIDTH-1:0] empty_d;

  // slot_q is the next slot to write; it starts at 1 after word0 and at 0 on later beats
  assign pop      = (state_q == ST_FILL) && (slot_q < SLOT_W'(WPB)) && (left_q != '0);
  assign left_d   = pop ? left_q - 1'b1 : left_q;
  assign slot_d   = pop ? slot_q + 1'b1 : slot_q;
  assign fill_end = (slot_d == SLOT_W'(WPB)) || (left_d == '0);

  always_comb begin
    int words;
    int pad;
    words   = int'(total_q) + 1;
    pad     = (WPB - (words % WPB)) % WPB;
    empty_d = EMPTY_WIDTH'(pad * BYTES_PER_PAIR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      total_q <= '0;
      left_q  <= '0;
      slot_q  <= '0;
      pack_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      empty_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            total_q <= bus.pair_num;
            left_q  <= bus.pair_num;
            slot_q  <= SLOT_W'(1);
            pack_q  <= DATA_WIDTH'(bus.pair_num);
            sop_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (pop) begin
            pack_q[PAIR_WIDTH*slot_q +: PAIR_WIDTH] <= bus.pair_data;
          end
          left_q <= left_d;
          slot_q <= slot_d;
          if (fill_end) begin
            valid_q <= 1'b1;
            eop_q   <= (left_d == '0);
            empty_q <= (left_d == '0) ? empty_d : '0;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (bus.src_ready) begin
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            if (eop_q) begin
              eop_q   <= 1'b0;
              empty_q <= '0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              pack_q  <= '0;
              slot_q  <= '0;
              state_q <= ST_FILL;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  avst_byte_reverse #(.DATA_WIDTH(DATA_WIDTH)) u_rev (
    .data_i(pack_q),
    .data_o(bus.src_data)
  );

  assign bus.pair_rd_en = pop;
  assign bus.src_valid  = valid_q;
  assign bus.src_sop    = sop_q;
  assign bus.src_eop    = eop_q;
  assign bus.src_empty  = empty_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_snp_pair_streamer.sv
// tb/tb_snp_pair_streamer.sv - scoreboard bench for snp_pair_streamer with randomized stalls
module tb_snp_pair_streamer;
  localparam int DW  = 512;
  localparam int PW  = 32;
  localparam int EW  = 6;
  localparam int CW  = 16;
  localparam int WPB = DW / PW;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  snp_pair_streamer_if #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .PAIR_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

  snp_pair_streamer #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .PAIR_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  beat_t         exp_q[$];
  logic [PW-1:0] fifo[$];
  int            checks = 0;
  int            errors = 0;
  int            pops = 0;
  int            done_cnt = 0;
  int            beats_in_pkt = 0;
  int            ready_mode = 0;
  bit            expect_done = 0;
  bit            pop_pend = 0;
  logic [DW-1:0] first_data;
  logic [EW-1:0] last_empty;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Reference: words are [N, pairs...], WPB per beat, zero padded; symbol s = byte s of the word stream
  task automatic push_expected(input int n, input logic [PW-1:0] pairs[$]);
    int words, nbeats;
    words  = n + 1;
    nbeats = (words + WPB - 1) / WPB;
    for (int b = 0; b < nbeats; b++) begin
      beat_t e;
      e.data = '0;
      for (int j = 0; j < WPB; j++) begin
        int idx;
        logic [PW-1:0] w;
        idx = b * WPB + j;
        if (idx == 0) w = PW'(n);
        else if (idx <= n) w = pairs[idx-1];
        else w = '0;
        for (int m = 0; m < PW / 8; m++) begin
          int s;
          s = (PW / 8) * j + m;
          e.data[DW-1-8*s -: 8] = w[8*m +: 8];
        end
      end
      e.sop   = (b == 0);
      e.eop   = (b == nbeats - 1);
      e.empty = e.eop ? EW'((nbeats * WPB - words) * (PW / 8)) : '0;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    bus.pair_data = '0;
    forever begin
      @(negedge clk);
      pop_pend = bus.pair_rd_en && !reset;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (pop_pend && !reset) begin
        if (fifo.size() > 0) void'(fifo.pop_front());
        else flag("fifo_underflow");
        pops++;
      end
      #1;
      bus.pair_data = (fifo.size() > 0) ? fifo[0] : '0;
    end
  end

  initial begin
    bus.src_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.src_ready = 1'b1;
        1:       bus.src_ready = 1'($urandom_range(1, 0));
        default: bus.src_ready = (beats_in_pkt == 0);
      endcase
    end
  end

  initial begin
    bit            stalled = 0;
    logic [DW-1:0] sv_data;
    logic          sv_sop, sv_eop;
    logic [EW-1:0] sv_empty;
    forever begin
      @(negedge clk);
      if (reset) begin
        stalled = 0;
        continue;
      end
      if (bus.done) done_cnt++;
      if (expect_done) begin
        check("done_after_eop", DW'(bus.done), DW'(1));
        expect_done = 0;
      end else if (bus.done) begin
        flag("done_unexpected");
      end
      if (bus.pair_rd_en && bus.src_valid) flag("pop_while_valid");
      if (bus.src_valid) begin
        if (stalled) begin
          check("stall_data", bus.src_data, sv_data);
          check("stall_sop", DW'(bus.src_sop), DW'(sv_sop));
          check("stall_eop", DW'(bus.src_eop), DW'(sv_eop));
          check("stall_empty", DW'(bus.src_empty), DW'(sv_empty));
        end
        if (bus.src_ready) begin
          stalled = 0;
          if (exp_q.size() == 0) begin
            flag("beat_unexpected");
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            check("beat_data", bus.src_data, e.data);
            check("beat_sop", DW'(bus.src_sop), DW'(e.sop));
            check("beat_eop", DW'(bus.src_eop), DW'(e.eop));
            check("beat_empty", DW'(bus.src_empty), DW'(e.empty));
          end
          if (bus.src_sop) first_data = bus.src_data;
          if (bus.src_eop) begin
            last_empty  = bus.src_empty;
            expect_done = 1;
          end
          beats_in_pkt++;
        end else begin
          stalled  = 1;
          sv_data  = bus.src_data;
          sv_sop   = bus.src_sop;
          sv_eop   = bus.src_eop;
          sv_empty = bus.src_empty;
        end
      end
    end
  end

  task automatic start_packet(input int n, input bit incr, output logic [PW-1:0] pairs[$]);
    pairs = {};
    for (int i = 0; i < n; i++) begin
      logic [PW-1:0] p;
      p = incr ? {16'(i + 1), 16'(i + 2)} : PW'($urandom);
      pairs.push_back(p);
      fifo.push_back(p);
    end
    push_expected(n, pairs);
    beats_in_pkt = 0;
    @(posedge clk);
    #1;
    bus.start    = 1'b1;
    bus.pair_num = CW'(n);
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.pair_num = CW'($urandom);
    check("busy_after_start", DW'(bus.busy), DW'(1));
  endtask

  task automatic run_packet(input int n, input int mode, input bit incr, input bit second_start);
    logic [PW-1:0] pairs[$];
    int pops0, done0, cyc;
    ready_mode = mode;
    pops0 = pops;
    done0 = done_cnt;
    start_packet(n, incr, pairs);
    if (second_start) begin
      repeat (3) @(posedge clk);
      #1;
      bus.start    = 1'b1;
      bus.pair_num = CW'(7);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    cyc = 0;
    while (done_cnt == done0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 5000) flag("timeout_done");
    repeat (5) @(negedge clk);
    check("pop_count", DW'(pops - pops0), DW'(n));
    check("done_count", DW'(done_cnt - done0), DW'(1));
    check("beats_left", DW'(exp_q.size()), DW'(0));
    check("busy_idle", DW'(bus.busy), DW'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, DW'(bus.src_valid), DW'(0));
    check({tag, "_sop"}, DW'(bus.src_sop), DW'(0));
    check({tag, "_eop"}, DW'(bus.src_eop), DW'(0));
    check({tag, "_empty"}, DW'(bus.src_empty), DW'(0));
    check({tag, "_busy"}, DW'(bus.busy), DW'(0));
    check({tag, "_done"}, DW'(bus.done), DW'(0));
    check({tag, "_rd_en"}, DW'(bus.pair_rd_en), DW'(0));
    check({tag, "_data"}, bus.src_data, '0);
  endtask

  initial begin
    logic [PW-1:0] pairs[$];
    int cyc;
    bus.start    = 1'b0;
    bus.pair_num = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_packet(0, 0, 0, 0);
    check("n0_empty", DW'(last_empty), DW'(60));
    run_packet(15, 0, 1, 0);
    check("n15_symbols0_3", DW'(first_data[DW-1 -: 32]), DW'(32'h0F00_0000));
    check("n15_empty", DW'(last_empty), DW'(0));
    run_packet(16, 0, 0, 0);
    check("n16_empty", DW'(last_empty), DW'(60));
    run_packet(40, 1, 0, 0);
    check("n40_empty", DW'(last_empty), DW'(28));
    run_packet(20, 0, 0, 1);

    ready_mode = 3;
    start_packet(30, 0, pairs);
    cyc = 0;
    while (!(bus.src_valid && beats_in_pkt == 1) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 2000) flag("timeout_beat2");
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    fifo.delete();
    expect_done = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    run_packet(1, 0, 0, 0);
    check("n1_empty", DW'(last_empty), DW'(56));

    for (int t = 0; t < 4; t++) begin
      run_packet($urandom_range(100, 0), $urandom_range(1, 0), 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
